uart_rx: RTL and testbench

Serial UART receiver feeding the ALU command interface: oversamples the asynchronous `i_rx` line at 16× baud, assembles 8N1 frames LSB-first and presents each byte with a one-cycle valid strobe. It sits directly upstream of the command/ALU interface, driving its received-data and receive-valid inputs. It contains its own baud tick generator, so the top level only routes the board clock, reset and the RX pin.

---
 rtl/uart_rx_pkg.sv | 33 +++
 rtl/baud_rate_gen.sv | 38 +++
 rtl/uart_rx.sv | 218 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg
// Shared definitions for the UART receive path and the command interface
// downstream of it:
//   - rx_state_t  : receiver FSM state encodings
//   - OVERSAMPLE  : number of baud ticks per serial bit
//   - CMD_*       : command byte constants understood by the command/ALU interface
//   - tick_divisor: clock-to-tick divisor for a given clock frequency and baud rate
// Optional feature macro used by the importers: UART_RX_PARITY_EN.

package uart_rx_pkg;

    localparam int OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    // Command bytes shared with the command/ALU interface
    localparam logic [7:0] CMD_A  = 8'h01;
    localparam logic [7:0] CMD_B  = 8'h02;
    localparam logic [7:0] CMD_OP = 8'h03;
    localparam logic [7:0] CMD_R  = 8'h04;

    // Truncating divisor; callers must pick clk_freq/baud so the result is >= 1
    function automatic int tick_divisor(input int clk_freq, input int baud);
        return clk_freq / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/baud_rate_gen.sv
// baud_rate_gen
// Free-running divider producing a one-clock tick every DIV clocks.
// It is never resynchronised to serial frames, so receivers see the tick
// with an arbitrary phase relative to the start edge.
// Parameters:
//   DIV    : clocks per tick (>= 1)
// Ports:
//   clk    : system clock
//   rst    : asynchronous active-high reset, counter returns to 0
//   o_tick : one-clock pulse when the counter wraps from DIV-1 to 0

module baud_rate_gen #(
    parameter int DIV = 162
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    // Counter runs 0..DIV-1 and wraps; with DIV = 1 it stays at 0 and ticks every clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign o_tick = (count == LAST);

endmodule

// File: rtl/uart_rx.sv
// uart_rx
// 16x-oversampling UART receiver (8N1 by default) that feeds received bytes
// to the command/ALU interface. Contains its own baud tick generator.
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit between
// the data bits and the stop bit; without it o_parity_err is constant 0.
// Parameters:
//   N        : data bits per frame
//   SB_TICK  : ticks spent in the stop bit (1..16)
//   CLK_FREQ : clock frequency in Hz
//   BAUD     : line baud rate
// Ports:
//   clk          : system clock
//   rst          : asynchronous active-high reset
//   i_rx         : serial line, idle high, asynchronous to clk
//   o_data       : last good received byte
//   o_rx_valid   : one-clock pulse, o_data just updated with a good frame
//   o_frame_err  : one-clock pulse, stop bit sampled low
//   o_parity_err : one-clock pulse, parity mismatch with a good stop bit

module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int N        = 8,
    parameter int SB_TICK  = 16,
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 19200
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_rx,
    output logic [N-1:0] o_data,
    output logic         o_rx_valid,
    output logic         o_frame_err,
    output logic         o_parity_err
);

    localparam int DIV = tick_divisor(CLK_FREQ, BAUD);
    localparam int NW  = (N > 1) ? $clog2(N) : 1;

    localparam logic [3:0]    S_MID      = 4'd7;
    localparam logic [3:0]    S_LAST     = 4'(OVERSAMPLE - 1);
    localparam logic [3:0]    S_STOP     = 4'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST     = NW'(N - 1);

    logic rx_meta;
    logic rx_sync;
    logic tick;

    rx_state_t     state, state_next;
    logic [3:0]    s, s_next;
    logic [NW-1:0] n, n_next;
    logic [N-1:0]  b, b_next;
    logic [N-1:0]  data_reg, data_next;
    logic          valid_reg, valid_next;
    logic          ferr_reg, ferr_next;
`ifdef UART_RX_PARITY_EN
    logic          par_bit, par_bit_next;
    logic          perr_reg, perr_next;
`endif

    baud_rate_gen #(
        .DIV (DIV)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .o_tick (tick)
    );

    // Two-flop synchroniser; resets to the idle-high line level so reset
    // release never looks like a start edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_sync <= rx_meta;
        end
    end

    // State register plus all datapath registers; strobes are registered so
    // they appear the clock after the final stop-bit sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            s         <= '0;
            n         <= '0;
            b         <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            ferr_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit   <= 1'b0;
            perr_reg  <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            s         <= s_next;
            n         <= n_next;
            b         <= b_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
            ferr_reg  <= ferr_next;
`ifdef UART_RX_PARITY_EN
            par_bit   <= par_bit_next;
            perr_reg  <= perr_next;
`endif
        end
    end

    // Next-state logic. IDLE reacts on every clock so a start bit directly
    // after a stop bit is caught; the other states only advance on ticks.
    always_comb begin
        state_next = state;
        s_next     = s;
        n_next     = n;
        b_next     = b;
        data_next  = data_reg;
        valid_next = 1'b0;
        ferr_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_next = par_bit;
        perr_next    = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (!rx_sync) begin
                    state_next = ST_START;
                    s_next     = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (s == S_MID) begin
                        // A start bit still low at its middle is genuine
                        if (!rx_sync) begin
                            state_next = ST_DATA;
                            s_next     = '0;
                            n_next     = '0;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        s_next = s + 4'd1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (s == S_LAST) begin
                        b_next = {rx_sync, b[N-1:1]};
                        s_next = '0;
                        if (n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_next = ST_PARITY;
`else
                            state_next = ST_STOP;
`endif
                        end else begin
                            n_next = n + NW'(1);
                        end
                    end else begin
                        s_next = s + 4'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    if (s == S_LAST) begin
                        par_bit_next = rx_sync;
                        s_next       = '0;
                        state_next   = ST_STOP;
                    end else begin
                        s_next = s + 4'd1;
                    end
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    if (s == S_STOP) begin
                        state_next = ST_IDLE;
                        // Frame error outranks parity error: one strobe per frame
                        if (!rx_sync) begin
                            ferr_next = 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if ((^b) ^ par_bit) begin
                            perr_next = 1'b1;
`endif
                        end else begin
                            valid_next = 1'b1;
                            data_next  = b;
                        end
                    end else begin
                        s_next = s + 4'd1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output drive from the registered values
    always_comb begin
        o_data      = data_reg;
        o_rx_valid  = valid_reg;
        o_frame_err = ferr_reg;
`ifdef UART_RX_PARITY_EN
        o_parity_err = perr_reg;
`else
        o_parity_err = 1'b0;
`endif
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx
// Directed, self-checking bench for uart_rx. Runs the receiver with a tick
// divisor of 4 (bit time 64 clocks) and drives hand-built serial frames.
// A negedge monitor counts output strobes and captures the data and cycle of
// each valid pulse. Also builds with UART_RX_PARITY_EN, in which case every
// frame carries an even parity bit and the parity cases are exercised.

module tb_uart_rx;

    localparam int N        = 8;
    localparam int SB_TICK  = 16;
    localparam int BAUD     = 19200;
    localparam int CLK_FREQ = BAUD * 16 * 4;
    localparam int DIV      = CLK_FREQ / (BAUD * 16);
    localparam int BIT      = DIV * 16;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         rx;
    logic [N-1:0] o_data;
    logic         o_rx_valid;
    logic         o_frame_err;
    logic         o_parity_err;

    int checks      = 0;
    int failures    = 0;
    int valid_count = 0;
    int ferr_count  = 0;
    int perr_count  = 0;
    int cyc         = 0;
    logic [7:0] cap_data [16];
    int         cap_cyc  [16];

    uart_rx #(
        .N        (N),
        .SB_TICK  (SB_TICK),
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_rx         (rx),
        .o_data       (o_data),
        .o_rx_valid   (o_rx_valid),
        .o_frame_err  (o_frame_err),
        .o_parity_err (o_parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Strobe monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (o_rx_valid) begin
            if (valid_count < 16) begin
                cap_data[valid_count] = o_data;
                cap_cyc[valid_count]  = cyc;
            end
            valid_count++;
        end
        if (o_frame_err)  ferr_count++;
        if (o_parity_err) perr_count++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic waitClocks(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic idleLine(input int cycles);
        rx = 1'b1;
        waitClocks(cycles);
    endtask

    // One serial frame; a low stop bit is released shortly after its middle so
    // the receiver's re-armed start detector sees it as a glitch
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit,
                                 input logic bad_parity);
        rx = 1'b0;
        waitClocks(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            waitClocks(BIT);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^data) ^ bad_parity;
        waitClocks(BIT);
`else
        if (bad_parity) $display("[TB] parity request ignored in 8N1 build");
`endif
        rx = stop_bit;
        if (stop_bit) begin
            waitClocks(BIT);
        end else begin
            waitClocks(44);
            rx = 1'b1;
            waitClocks(BIT - 44);
        end
        rx = 1'b1;
    endtask

    initial begin
        int v0;
        int f0;
        int p0;
        int gap;

        $display("[TB] start, DIV=%0d bit=%0d clocks", DIV, BIT);
        rst = 1'b1;
        rx  = 1'b1;
        waitClocks(3);
        checkOutput("reset_data",   32'(o_data),       32'h0);
        checkOutput("reset_valid",  32'(o_rx_valid),   32'h0);
        checkOutput("reset_ferr",   32'(o_frame_err),  32'h0);
        checkOutput("reset_perr",   32'(o_parity_err), 32'h0);
        rst = 1'b0;
        idleLine(BIT);

        // Single good frame
        v0 = valid_count;
        f0 = ferr_count;
        applyStimulus(8'hA5, 1'b1, 1'b0);
        idleLine(BIT);
        checkOutput("a5_valid_pulses", 32'(valid_count - v0), 32'd1);
        checkOutput("a5_captured",     32'(cap_data[v0]),     32'hA5);
        checkOutput("a5_data_held",    32'(o_data),           32'hA5);
        checkOutput("a5_no_ferr",      32'(ferr_count - f0),  32'd0);

        // Back-to-back frames with no idle gap
        v0 = valid_count;
        applyStimulus(8'h01, 1'b1, 1'b0);
        applyStimulus(8'h3C, 1'b1, 1'b0);
        idleLine(BIT);
        checkOutput("b2b_valid_pulses", 32'(valid_count - v0), 32'd2);
        checkOutput("b2b_first",        32'(cap_data[v0]),     32'h01);
        checkOutput("b2b_second",       32'(cap_data[v0 + 1]), 32'h3C);
        gap = cap_cyc[v0 + 1] - cap_cyc[v0];
        checkOutput("b2b_gap_in_range",
                    32'((gap >= FRAME_BITS * BIT - DIV) && (gap <= FRAME_BITS * BIT + DIV)),
                    32'd1);

        // Short low glitch (4 ticks) is rejected, then a normal frame follows
        v0 = valid_count;
        f0 = ferr_count;
        rx = 1'b0;
        waitClocks(4 * DIV);
        idleLine(2 * BIT);
        checkOutput("glitch_no_valid", 32'(valid_count - v0), 32'd0);
        checkOutput("glitch_no_ferr",  32'(ferr_count - f0),  32'd0);
        applyStimulus(8'h55, 1'b1, 1'b0);
        idleLine(BIT);
        checkOutput("after_glitch_pulses", 32'(valid_count - v0), 32'd1);
        checkOutput("after_glitch_data",   32'(o_data),           32'h55);

        // Stop bit low: frame error, data kept
        v0 = valid_count;
        f0 = ferr_count;
        applyStimulus(8'hFF, 1'b0, 1'b0);
        idleLine(2 * BIT);
        checkOutput("ferr_pulses",   32'(ferr_count - f0),  32'd1);
        checkOutput("ferr_no_valid", 32'(valid_count - v0), 32'd0);
        checkOutput("ferr_data_kept", 32'(o_data),          32'h55);

        // Reset in the middle of 0x80 after three data bits
        v0 = valid_count;
        f0 = ferr_count;
        rx = 1'b0;
        waitClocks(BIT);
        waitClocks(3 * BIT + BIT / 2);
        rst = 1'b1;
        rx  = 1'b1;
        waitClocks(1);
        checkOutput("midrst_data",  32'(o_data),      32'h0);
        checkOutput("midrst_valid", 32'(o_rx_valid),  32'h0);
        checkOutput("midrst_ferr",  32'(o_frame_err), 32'h0);
        rst = 1'b0;
        idleLine(3 * BIT);
        checkOutput("midrst_no_valid", 32'(valid_count - v0), 32'd0);
        checkOutput("midrst_no_ferr",  32'(ferr_count - f0),  32'd0);
        applyStimulus(8'h7E, 1'b1, 1'b0);
        idleLine(BIT);
        checkOutput("after_rst_pulses", 32'(valid_count - v0), 32'd1);
        checkOutput("after_rst_data",   32'(o_data),           32'h7E);

`ifdef UART_RX_PARITY_EN
        // 0x03 has even ones, so a parity bit of 1 is a mismatch
        v0 = valid_count;
        p0 = perr_count;
        applyStimulus(8'h03, 1'b1, 1'b1);
        idleLine(BIT);
        checkOutput("par_bad_perr",     32'(perr_count - p0),  32'd1);
        checkOutput("par_bad_no_valid", 32'(valid_count - v0), 32'd0);
        checkOutput("par_bad_data_kept", 32'(o_data),          32'h7E);
        applyStimulus(8'h03, 1'b1, 1'b0);
        idleLine(BIT);
        checkOutput("par_good_valid", 32'(valid_count - v0), 32'd1);
        checkOutput("par_good_data",  32'(o_data),           32'h03);
        checkOutput("par_good_no_perr", 32'(perr_count - p0), 32'd1);
`else
        p0 = 0;
        checkOutput("no_parity_pulses", 32'(perr_count - p0), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
